// File: rtl/ntt_row_sched_pkg.sv
// Shared types and defaults for the NTT row scheduler.
// Imported by the interface, the delay line and the scheduler top.
package ntt_pkg;

  localparam int NTT_N   = 64;
  localparam int MAC_LAT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ntt_sched_state_t;

endpackage

// File: rtl/ntt_row_sched_if.sv
// Control and operand-issue bundle between the NTT wrapper,
// the row scheduler and the rowcalc/x/w/y datapath.
interface ntt_row_sched_if
  import ntt_pkg::*;
#(
  parameter int IDXW = $clog2(NTT_N)
);

  logic            start;
  logic            abort;
  logic            busy;
  logic            done;
  logic [IDXW-1:0] x_addr;
  logic [IDXW-1:0] w_row;
  logic [IDXW-1:0] w_col;
  logic            mac_valid;
  logic            mac_first;
  logic            mac_last;
  logic            y_we;
  logic [IDXW-1:0] y_addr;

  modport master (
    output start, abort,
    input  busy, done,
    input  x_addr, w_row, w_col,
    input  mac_valid, mac_first, mac_last,
    input  y_we, y_addr
  );

  modport slave (
    input  start, abort,
    output busy, done,
    output x_addr, w_row, w_col,
    output mac_valid, mac_first, mac_last,
    output y_we, y_addr
  );

endinterface

// File: rtl/ntt_wb_delay.sv
// LAT-stage {valid,row} shift register aligning row write-back
// with the rowcalc pipeline; pend flags entries not yet at the output.
module ntt_wb_delay
  import ntt_pkg::*;
#(
  parameter int LAT  = MAC_LAT,
  parameter int IDXW = $clog2(NTT_N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            din_v,
  input  logic [IDXW-1:0] din_row,
  output logic            dout_v,
  output logic [IDXW-1:0] dout_row,
  output logic            pend
);

  localparam int W = 1 + IDXW;

  logic [LAT*W-1:0] sr;
  logic [LAT*W-1:0] sr_nxt;

  // Stage 0 sits in the low bits; the oldest entry at the top.
  always_comb begin
    sr_nxt = sr << W;
    sr_nxt[W-1:0] = {din_v, din_row};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
    end else begin
      sr <= sr_nxt;
    end
  end

  assign {dout_v, dout_row} = sr[LAT*W-1 -: W];

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pend = pend | sr[i*W+IDXW];
    end
  end

endmodule

// File: rtl/ntt_row_sched.sv
// Sequences the shared rowcalc MAC through an N x N matrix-vector
// product and writes each row result after the pipeline latency.
module ntt_row_sched
  import ntt_pkg::*;
#(
  parameter  int N    = NTT_N,
  parameter  int LAT  = MAC_LAT,
  localparam int IDXW = $clog2(N)
) (
  input logic          clk,
  input logic          rst,
  ntt_row_sched_if.slave bus
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW-1:0] PENU = IDXW'(N - 2);

  ntt_sched_state_t st;

  logic [IDXW-1:0] r;
  logic [IDXW-1:0] c;
  logic            mv;
  logic            mf;
  logic            ml;
  logic            bz;
  logic            dn;

  logic            wb_in_v;
  logic [IDXW-1:0] wb_in_row;
  logic            wb_v;
  logic [IDXW-1:0] wb_row;
  logic            wb_pend;

  // Only row-closing issues enter the line, so y_we never
  // fires for a mid-row operand.
  assign wb_in_v   = mv & ml;
  assign wb_in_row = wb_in_v ? r : '0;

  ntt_wb_delay #(
    .LAT  (LAT),
    .IDXW (IDXW)
  ) u_wb (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.abort),
    .din_v    (wb_in_v),
    .din_row  (wb_in_row),
    .dout_v   (wb_v),
    .dout_row (wb_row),
    .pend     (wb_pend)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      st <= IDLE;
      r  <= '0;
      c  <= '0;
      mv <= 1'b0;
      mf <= 1'b0;
      ml <= 1'b0;
      bz <= 1'b0;
      dn <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            st <= ISSUE;
            mv <= 1'b1;
            mf <= 1'b1;
            bz <= 1'b1;
          end
        end
        ISSUE: begin
          if (r == LAST && c == LAST) begin
            st <= DRAIN;
            mv <= 1'b0;
            mf <= 1'b0;
            ml <= 1'b0;
            r  <= '0;
            c  <= '0;
          end else begin
            mf <= (c == LAST);
            ml <= (c == PENU);
            if (c == LAST) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Rows drain in order, so an empty line behind
          // the emerging write means it is the final one.
          if (wb_v && !wb_pend) begin
            st <= DONE;
            bz <= 1'b0;
            dn <= 1'b1;
          end
        end
        DONE: begin
          st <= IDLE;
          dn <= 1'b0;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = bz;
  assign bus.done      = dn;
  assign bus.mac_valid = mv;
  assign bus.mac_first = mf;
  assign bus.mac_last  = ml;
  assign bus.x_addr    = c;
  assign bus.w_col     = c;
  assign bus.w_row     = r;
  assign bus.y_we      = wb_v;
  assign bus.y_addr    = wb_row;

endmodule

// File: tb/tb_ntt_row_sched.sv
// Directed bench for ntt_row_sched: a hand table for N=4/LAT=2 plus
// timing-formula checks for abort, restart, reset, LAT=1 and defaults.
module tb_ntt_row_sched;

  typedef struct packed {
    logic       v;
    logic       f;
    logic       l;
    logic       we;
    logic       dn;
    logic       bz;
    logic [7:0] xa;
    logic [7:0] wr;
    logic [7:0] wc;
    logic [7:0] ya;
  } obs_t;

  typedef struct {
    bit   st;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ntt_row_sched_if #(.IDXW(2)) ifa ();
  ntt_row_sched_if #(.IDXW(2)) ifb ();
  ntt_row_sched_if #(.IDXW(6)) ifc ();

  ntt_row_sched #(.N(4), .LAT(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  ntt_row_sched #(.N(4), .LAT(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  ntt_row_sched dut_c (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  obs_t oa, ob, oc;

  always_comb begin
    oa    = '0;
    oa.v  = ifa.mac_valid;
    oa.f  = ifa.mac_first;
    oa.l  = ifa.mac_last;
    oa.we = ifa.y_we;
    oa.dn = ifa.done;
    oa.bz = ifa.busy;
    oa.xa = 8'(ifa.x_addr);
    oa.wr = 8'(ifa.w_row);
    oa.wc = 8'(ifa.w_col);
    oa.ya = 8'(ifa.y_addr);
  end

  always_comb begin
    ob    = '0;
    ob.v  = ifb.mac_valid;
    ob.f  = ifb.mac_first;
    ob.l  = ifb.mac_last;
    ob.we = ifb.y_we;
    ob.dn = ifb.done;
    ob.bz = ifb.busy;
    ob.xa = 8'(ifb.x_addr);
    ob.wr = 8'(ifb.w_row);
    ob.wc = 8'(ifb.w_col);
    ob.ya = 8'(ifb.y_addr);
  end

  always_comb begin
    oc    = '0;
    oc.v  = ifc.mac_valid;
    oc.f  = ifc.mac_first;
    oc.l  = ifc.mac_last;
    oc.we = ifc.y_we;
    oc.dn = ifc.done;
    oc.bz = ifc.busy;
    oc.xa = 8'(ifc.x_addr);
    oc.wr = 8'(ifc.w_row);
    oc.wc = 8'(ifc.w_col);
    oc.ya = 8'(ifc.y_addr);
  end

  function automatic obs_t get(input int w);
    case (w)
      0:       return oa;
      1:       return ob;
      default: return oc;
    endcase
  endfunction

  task automatic set_in(input int w, input bit s, input bit a);
    case (w)
      0: begin ifa.start = s; ifa.abort = a; end
      1: begin ifb.start = s; ifb.abort = a; end
      default: begin ifc.start = s; ifc.abort = a; end
    endcase
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("v%0b f%0b l%0b x%0d wr%0d wc%0d we%0b ya%0d dn%0b bz%0b",
      o.v, o.f, o.l, o.xa, o.wr, o.wc, o.we, o.ya, o.dn, o.bz);
  endfunction

  task automatic cmp(input obs_t got, input obs_t exp,
                     input string tag, input int cyc);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got {%s} want {%s}",
        tag, cyc, fmt(got), fmt(exp));
    end
  endtask

  function automatic vec_t mk(input bit st, input bit v, input bit f,
                              input bit l, input int xa, input int wr,
                              input bit we, input int ya, input bit dn,
                              input bit bz);
    vec_t t;
    t.st   = st;
    t.e    = '0;
    t.e.v  = v;
    t.e.f  = f;
    t.e.l  = l;
    t.e.xa = 8'(xa);
    t.e.wc = 8'(xa);
    t.e.wr = 8'(wr);
    t.e.we = we;
    t.e.ya = 8'(ya);
    t.e.dn = dn;
    t.e.bz = bz;
    return t;
  endfunction

  // Called just after the start edge k; checks cycles k+1..k+ncyc from
  // the closed-form timing. ab_at/st_at pulse abort/start at that cycle.
  task automatic check_run(input int w, input int n, input int lat,
                           input int ncyc, input int ab_at,
                           input int st_at, input bit hold,
                           input string tag);
    for (int j = 1; j <= ncyc; j++) begin
      obs_t e;
      bit   alive;
      int   i;
      @(negedge clk);
      e     = '0;
      alive = (ab_at < 0) || (j <= ab_at);
      i     = j - 1;
      if (alive && i < n * n) begin
        e.v  = 1'b1;
        e.f  = (i % n == 0);
        e.l  = (i % n == n - 1);
        e.xa = 8'(i % n);
        e.wc = 8'(i % n);
        e.wr = 8'(i / n);
      end
      if (alive && j > lat && (j - lat) % n == 0 && (j - lat) / n <= n) begin
        e.we = 1'b1;
        e.ya = 8'((j - lat) / n - 1);
      end
      if (alive && j == n * n + lat + 1) e.dn = 1'b1;
      if (alive && j <= n * n + lat) e.bz = 1'b1;
      cmp(get(w), e, tag, j);
      set_in(w, hold || (j == st_at), j == ab_at);
    end
  endtask

  task automatic expect_idle(input int w, input string tag);
    @(negedge clk);
    cmp(get(w), '0, tag, 0);
  endtask

  task automatic kick(input int w);
    set_in(w, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 1'b0);
  endtask

  vec_t tbl[21];

  initial begin
    set_in(0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0);
    set_in(2, 1'b0, 1'b0);

    tbl[0]  = mk(1, 0,0,0, 0,0, 0,0, 0,0);
    tbl[1]  = mk(0, 1,1,0, 0,0, 0,0, 0,1);
    tbl[2]  = mk(0, 1,0,0, 1,0, 0,0, 0,1);
    tbl[3]  = mk(0, 1,0,0, 2,0, 0,0, 0,1);
    tbl[4]  = mk(0, 1,0,1, 3,0, 0,0, 0,1);
    tbl[5]  = mk(0, 1,1,0, 0,1, 0,0, 0,1);
    tbl[6]  = mk(0, 1,0,0, 1,1, 1,0, 0,1);
    tbl[7]  = mk(0, 1,0,0, 2,1, 0,0, 0,1);
    tbl[8]  = mk(0, 1,0,1, 3,1, 0,0, 0,1);
    tbl[9]  = mk(0, 1,1,0, 0,2, 0,0, 0,1);
    tbl[10] = mk(0, 1,0,0, 1,2, 1,1, 0,1);
    tbl[11] = mk(0, 1,0,0, 2,2, 0,0, 0,1);
    tbl[12] = mk(0, 1,0,1, 3,2, 0,0, 0,1);
    tbl[13] = mk(0, 1,1,0, 0,3, 0,0, 0,1);
    tbl[14] = mk(0, 1,0,0, 1,3, 1,2, 0,1);
    tbl[15] = mk(0, 1,0,0, 2,3, 0,0, 0,1);
    tbl[16] = mk(0, 1,0,1, 3,3, 0,0, 0,1);
    tbl[17] = mk(0, 0,0,0, 0,0, 0,0, 0,1);
    tbl[18] = mk(0, 0,0,0, 0,0, 1,3, 0,1);
    tbl[19] = mk(0, 0,0,0, 0,0, 0,0, 1,0);
    tbl[20] = mk(0, 0,0,0, 0,0, 0,0, 0,0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_idle(0, "reset_a");
    cmp(get(1), '0, "reset_b", 0);
    cmp(get(2), '0, "reset_c", 0);
    @(posedge clk);
    #1;

    // Basic transform, N=4 LAT=2, hand table.
    for (int t = 0; t < 21; t++) begin
      set_in(0, tbl[t].st, 1'b0);
      @(negedge clk);
      cmp(oa, tbl[t].e, "tbl", t);
      @(posedge clk);
      #1;
    end

    // Abort at cycle 7, then restart at cycle 10.
    kick(0);
    check_run(0, 4, 2, 10, 7, -1, 1'b0, "abort");
    set_in(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0);
    check_run(0, 4, 2, 20, -1, -1, 1'b0, "restart");

    // start held high: back-to-back transforms; mid-ISSUE start ignored.
    set_in(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_run(0, 4, 2, 19, -1, -1, 1'b1, "hold1");
    @(posedge clk);
    #1;
    expect_idle(0, "hold_gap");
    @(posedge clk);
    #1;
    check_run(0, 4, 2, 19, -1, 5, 1'b0, "hold2");
    expect_idle(0, "hold_end");
    expect_idle(0, "hold_end");

    // rst at cycle 9 with start high, then start+abort together.
    kick(0);
    check_run(0, 4, 2, 9, -1, -1, 1'b0, "pre_rst");
    rst = 1'b1;
    set_in(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 1'b0, 1'b0);
    expect_idle(0, "rst_mid");
    expect_idle(0, "rst_mid");
    @(posedge clk);
    #1;
    set_in(0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) expect_idle(0, "start_abort");

    // LAT=1: row write coincides with next row's first issue.
    @(posedge clk);
    #1;
    kick(1);
    check_run(1, 4, 1, 20, -1, -1, 1'b0, "lat1");

    // Default parameters, full 64x64 sweep.
    @(posedge clk);
    #1;
    kick(2);
    check_run(2, 64, 8, 4107, -1, -1, 1'b0, "n64");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
